// File: rtl/ahb_default_slave_v2.sv
// ============================================================================
// ahb_default_slave_v2 : AHB-Lite default slave with wait states, ERROR or
//                        RAZ/WI response, and a sticky first-error log.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ahb_default_slave_v2 #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    WAIT_STATES   = 0,
  parameter int                    RESP_MODE     = 0,
  parameter logic [DATA_WIDTH-1:0] RDATA_PATTERN = '0,
  parameter int                    CNT_WIDTH     = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  input  logic                  err_clear,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write,
  output logic [2:0]            err_size,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? WCW'(WAIT_STATES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ERR1 = 3'd2,
    S_ERR2 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [WCW-1:0]          wcnt_q, wcnt_d;
  logic                    write_q, write_d;
  logic                    hreadyout_q, hreadyout_d;
  logic [1:0]              hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
  logic                    err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic                    err_write_q, err_write_d;
  logic [2:0]              err_size_q, err_size_d;
  logic [CNT_WIDTH-1:0]    err_count_q, err_count_d;
  logic                    can_accept;
  logic                    accept;
  state_t                  resp_state;

  // Write data and the SEQ/NONSEQ distinction carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{HWDATA, HTRANS[0]};

  always_comb begin
    resp_state  = (RESP_MODE != 0) ? S_DONE : S_ERR1;
    can_accept  = (state_q == S_IDLE) || (state_q == S_ERR2) || (state_q == S_DONE);
    accept      = HSEL & HTRANS[1] & HREADY & can_accept;

    state_d = state_q;
    wcnt_d  = wcnt_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (wcnt_q == '0) state_d = resp_state;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (accept) begin
          write_d = HWRITE;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_LOAD;
          end else begin
            state_d = resp_state;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Bus outputs are registered copies decoded from the next state.
    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;
    hrdata_d    = ((state_d == S_DONE) && !write_d) ? RDATA_PATTERN : '0;

    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    err_size_d  = err_size_q;
    err_count_d = err_count_q;
    if (err_clear) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_write_d = 1'b0;
      err_size_d  = '0;
      err_count_d = '0;
    end
    if (accept) begin
      if (!err_valid_d) begin
        err_valid_d = 1'b1;
        err_addr_d  = HADDR;
        err_write_d = HWRITE;
        err_size_d  = HSIZE;
      end
      if (!(&err_count_d)) err_count_d = err_count_d + 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
      hrdata_q    <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
      err_size_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_size_q  <= err_size_d;
      err_count_q <= err_count_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_write = err_write_q;
  assign err_size  = err_size_q;
  assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: doc/ahb_default_slave_v2.md
# ahb_default_slave_v2

Parametrised successor to the fabric's default AHB slave: it terminates every transfer that decodes to no mapped slave. It adds a spec-compliant two-cycle ERROR response, a configurable number of wait states, and a selectable read-as-zero/write-ignored (RAZ/WI) OKAY mode. It also keeps a sticky first-error log with a saturating error counter for debug and software readback. It sits on the AHB-Lite decoder's default HSEL leg, and its HREADYOUT/HRESP/HRDATA feed the response mux.

## Interface
- ADDR_WIDTH, 32, HADDR / logged address width
- DATA_WIDTH, 32, HWDATA/HRDATA width
- WAIT_STATES, 0, data-phase wait cycles inserted before the response (legal 0..15)
- RESP_MODE, 0, 0 = ERROR response; 1 = RAZ/WI OKAY response
- RDATA_PATTERN, 0, DATA_WIDTH value returned on reads in RESP_MODE 1
- CNT_WIDTH, 16, error counter width

- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  default-slave select from the decoder
- HADDR  in  ADDR_WIDTH  address-phase address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  address-phase direction
- HSIZE  in  3  address-phase size
- HREADY  in  1  bus-level ready (address-phase qualifier)
- HWDATA  in  DATA_WIDTH  ignored (write data discarded)
- HRDATA  out  DATA_WIDTH  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  2  OKAY=00, ERROR=01
- err_clear  in  1  single-cycle pulse; clears log and counter
- err_valid  out  1  sticky: at least one transfer logged since clear
- err_addr  out  ADDR_WIDTH  HADDR of first logged transfer
- err_write  out  1  HWRITE of first logged transfer
- err_size  out  3  HSIZE of first logged transfer
- err_count  out  CNT_WIDTH  logged transfers, saturating at all-ones

## Operation
- Accept condition: HSEL & HTRANS[1] & HREADY at a rising edge. IDLE and BUSY transfers, or cycles with HREADY low, are never accepted and get a zero-wait OKAY.
- FSM states: IDLE, WAIT, ERR1, ERR2, DONE. All outputs are decoded from registered state.
  - IDLE: HREADYOUT=1, HRESP=OKAY, HRDATA=0.
  - WAIT: HREADYOUT=0, HRESP=OKAY. The down-counter, of width clog2(WAIT_STATES+1), is loaded on accept.
  - ERR1: HREADYOUT=0, HRESP=ERROR.
  - ERR2: HREADYOUT=1, HRESP=ERROR.
  - DONE (RESP_MODE 1): HREADYOUT=1, HRESP=OKAY. HRDATA=RDATA_PATTERN if the captured HWRITE=0, else 0.
- Transitions:
  - On accept from IDLE/ERR2/DONE: to WAIT if WAIT_STATES>0, else to ERR1 (mode 0) or DONE (mode 1).
  - WAIT: decrements each cycle. When the counter is 0, go to ERR1 or DONE.
  - ERR1: always to ERR2.
  - ERR2/DONE: to IDLE when there is no accept. A new accept in that same cycle starts the next transfer back-to-back.
- Log:
  - Every accepted transfer increments err_count, in both modes. The counter saturates and never wraps.
  - If err_valid=0 on accept, capture HADDR/HWRITE/HSIZE and set err_valid. Later transfers do not overwrite the capture.
  - err_clear alone: err_valid=0, err_count=0, capture fields=0.
  - err_clear and accept in the same cycle: the new transfer is captured, err_valid=1, err_count=1.
- HWDATA is never stored. Writes have no side effect in either mode.

## Timing
- Reset: state=IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, counter=0, err_valid=0, err_addr=0, err_write=0, err_size=0, err_count=0.
- Reset mid-transfer (any state) returns to IDLE on the next edge. No response completes and the log is cleared.
- Accept at edge T, mode 0, WAIT_STATES=N:
  - cycles T+1..T+N: WAIT.
  - T+N+1: ERR1.
  - T+N+2: ERR2.
  - Data-phase latency is N+2 cycles.
- Mode 1: T+1..T+N WAIT, then T+N+1 DONE. Latency is N+1 cycles.
- Log outputs update at the accept edge T and are visible from T+1.
- Accept is only possible in IDLE/ERR2/DONE, because HREADY is low in all other states.

## Test plan
- Mode 0, N=0: NONSEQ read to 0x4000_0000 → T+1 HREADYOUT=0/HRESP=01; T+2 HREADYOUT=1/HRESP=01; T+3 IDLE with 1/00. err_valid=1, err_addr=0x4000_0000, err_count=1.
- Mode 0, N=3: NONSEQ write → 3 cycles of HREADYOUT=0/OKAY, then ERR1, then ERR2. A second NONSEQ accepted during ERR2 goes straight to WAIT. err_count=2 and err_addr keeps the first address.
- Mode 1, RDATA_PATTERN=0xDEADBEEF, N=1: read → T+1 HREADYOUT=0; T+2 HREADYOUT=1, OKAY, HRDATA=0xDEADBEEF. Write → HRDATA=0, OKAY.
- HTRANS=IDLE/BUSY with HSEL=1, and NONSEQ with HREADY=0 → no state change, HREADYOUT=1, OKAY, err_count unchanged.
- CNT_WIDTH=2: five accepts → err_count=3 (saturated). err_clear together with a 6th accept to 0x10 → err_count=1, err_addr=0x10, err_valid=1.
- HRESET asserted during ERR1 → next cycle HREADYOUT=1, HRESP=00, all log outputs 0.
